lmc1992_receiver: RTL and testbench

// Microwire slave: the far end of the STE shifter's microwire master. Deserialises
// 11-bit LMC1992 command frames from MWCLK/MWDATA/MWE_N and holds the decoded

---
 rtl/lmc1992_pkg.sv | 46 ++++
 rtl/lmc1992_receiver_if.sv | 30 +++
 rtl/lmc_gain_lut.sv | 10 +
 rtl/lmc1992_receiver.sv | 137 +++++++++++++
 tb/tb_lmc1992_receiver.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/lmc1992_pkg.sv
// Shared definitions for the LMC1992 microwire receiver.
// Function codes, register limits, reset defaults, FSM states, the
// attenuation-to-linear-gain table and small clamp helpers.
package lmc1992_pkg;

  localparam int FRAME_BITS = 11;

  localparam logic [2:0] FN_MIX    = 3'b000;
  localparam logic [2:0] FN_BASS   = 3'b001;
  localparam logic [2:0] FN_TREBLE = 3'b010;
  localparam logic [2:0] FN_MASTER = 3'b011;
  localparam logic [2:0] FN_RIGHT  = 3'b100;
  localparam logic [2:0] FN_LEFT   = 3'b101;

  localparam logic [3:0] MAX_TONE   = 4'd12;
  localparam logic [5:0] MAX_MASTER = 6'd40;
  localparam logic [4:0] MAX_SIDE   = 5'd20;

  localparam logic [1:0] RST_MIX  = 2'b01;
  localparam logic [3:0] RST_TONE = 4'd6;
  localparam logic [7:0] RST_GAIN = 8'd255;

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  // round_half_up(255 * 10^(-k/10)) in 2 dB steps; everything from k=28 on
  // rounds to zero, and k>=40 is forced to zero anyway.
  localparam logic [0:60][7:0] GAIN_TABLE = {
    8'd255, 8'd203, 8'd161, 8'd128, 8'd102, 8'd81, 8'd64, 8'd51,
    8'd40,  8'd32,  8'd26,  8'd20,  8'd16,  8'd13, 8'd10, 8'd8,
    8'd6,   8'd5,   8'd4,   8'd3,   8'd3,   8'd2,  8'd2,  8'd1,
    8'd1,   8'd1,   8'd1,   8'd1,   {33{8'd0}}
  };

  function automatic logic [3:0] clamp_tone(logic [3:0] v);
    return (v > MAX_TONE) ? MAX_TONE : v;
  endfunction

  function automatic logic [5:0] clamp_master(logic [5:0] v);
    return (v > MAX_MASTER) ? MAX_MASTER : v;
  endfunction

  function automatic logic [4:0] clamp_side(logic [4:0] v);
    return (v > MAX_SIDE) ? MAX_SIDE : v;
  endfunction

endpackage

// File: rtl/lmc1992_receiver_if.sv
// Microwire pins plus the decoded register / gain outputs of the receiver.
// master: the shifter side (drives the microwire lines, observes results).
// slave : the receiver.
interface lmc1992_receiver_if;
  logic       mw_clk;
  logic       mw_data;
  logic       mw_en_n;
  logic [1:0] mix;
  logic [3:0] bass;
  logic [3:0] treble;
  logic [5:0] master_vol;
  logic [4:0] left_vol;
  logic [4:0] right_vol;
  logic [7:0] gain_left;
  logic [7:0] gain_right;
  logic       cmd_valid;
  logic       frame_err;

  modport master (
    output mw_clk, mw_data, mw_en_n,
    input  mix, bass, treble, master_vol, left_vol, right_vol,
           gain_left, gain_right, cmd_valid, frame_err
  );

  modport slave (
    input  mw_clk, mw_data, mw_en_n,
    output mix, bass, treble, master_vol, left_vol, right_vol,
           gain_left, gain_right, cmd_valid, frame_err
  );
endinterface

// File: rtl/lmc_gain_lut.sv
// Attenuation step (2 dB units, 0..60) to linear 8-bit gain.
// step in 6, gain out 8. Purely combinational.
module lmc_gain_lut
  import lmc1992_pkg::*;
(
  input  logic [5:0] step,
  output logic [7:0] gain
);
  assign gain = (step >= 6'd40) ? 8'd0 : GAIN_TABLE[step];
endmodule

// File: rtl/lmc1992_receiver.sv
// LMC1992 microwire slave: synchronises MWCLK/MWDATA/MWE_N, deserialises
// 11-bit frames, updates tone/mix/volume registers and derives L/R gains.
// Ports: clk32 (32 MHz), reset (async, active high), bus (slave modport:
// microwire inputs, register/gain outputs, cmd_valid/frame_err pulses).
module lmc1992_receiver
  import lmc1992_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [1:0] DEV_ADDR    = 2'b10
) (
  input logic            clk32,
  input logic            reset,
  lmc1992_receiver_if.slave bus
);
  logic [SYNC_STAGES-1:0] clk_sync, dat_sync, en_sync;
  logic clk_q, en_q;
  logic clk_rise, en_rise, en_fall, data;

  // en_n resets high so reset release never looks like a frame start.
  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      clk_sync <= '0;
      dat_sync <= '0;
      en_sync  <= '1;
      clk_q    <= 1'b0;
      en_q     <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], bus.mw_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], bus.mw_data};
      en_sync  <= {en_sync[SYNC_STAGES-2:0], bus.mw_en_n};
      clk_q    <= clk_sync[SYNC_STAGES-1];
      en_q     <= en_sync[SYNC_STAGES-1];
    end
  end

  assign data     = dat_sync[SYNC_STAGES-1];
  assign clk_rise = clk_sync[SYNC_STAGES-1] & ~clk_q;
  assign en_rise  = en_sync[SYNC_STAGES-1] & ~en_q;
  assign en_fall  = ~en_sync[SYNC_STAGES-1] & en_q;

  state_t      state, state_n;
  logic [10:0] sr, sr_n;
  logic [3:0]  cnt, cnt_n;
  logic        set_err, set_valid;
  logic [2:0]  fn;
  logic [5:0]  d;

  assign fn = sr[8:6];
  assign d  = sr[5:0];

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      sr    <= sr_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    sr_n      = sr;
    cnt_n     = cnt;
    set_err   = 1'b0;
    set_valid = 1'b0;
    unique case (state)
      IDLE: if (en_fall) begin
        state_n = SHIFT;
        sr_n    = '0;
        cnt_n   = '0;
      end
      SHIFT: begin
        if (en_fall) begin
          sr_n  = '0;
          cnt_n = '0;
        end else begin
          // A clock edge coinciding with the closing edge still counts.
          if (clk_rise) begin
            sr_n = {sr[9:0], data};
            if (cnt != 4'hF) cnt_n = cnt + 4'd1;
          end
          if (en_rise) state_n = CHECK;
        end
      end
      CHECK: begin
        state_n = IDLE;
        if (cnt != 4'(FRAME_BITS)) set_err = 1'b1;
        else if (sr[10:9] == DEV_ADDR && fn <= FN_LEFT) set_valid = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  logic [5:0] step_l, step_r;
  logic [7:0] lut_l, lut_r;

  assign step_l = (MAX_MASTER - bus.master_vol) + 6'(MAX_SIDE - bus.left_vol);
  assign step_r = (MAX_MASTER - bus.master_vol) + 6'(MAX_SIDE - bus.right_vol);

  lmc_gain_lut u_lut_l (.step(step_l), .gain(lut_l));
  lmc_gain_lut u_lut_r (.step(step_r), .gain(lut_r));

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      bus.mix        <= RST_MIX;
      bus.bass       <= RST_TONE;
      bus.treble     <= RST_TONE;
      bus.master_vol <= MAX_MASTER;
      bus.left_vol   <= MAX_SIDE;
      bus.right_vol  <= MAX_SIDE;
      bus.gain_left  <= RST_GAIN;
      bus.gain_right <= RST_GAIN;
      bus.cmd_valid  <= 1'b0;
      bus.frame_err  <= 1'b0;
    end else begin
      // Gains track the volume registers with one cycle of latency.
      bus.gain_left  <= lut_l;
      bus.gain_right <= lut_r;
      bus.cmd_valid  <= set_valid;
      bus.frame_err  <= set_err;
      if (set_valid) begin
        unique case (fn)
          FN_MIX:    bus.mix        <= d[1:0];
          FN_BASS:   bus.bass       <= clamp_tone(d[3:0]);
          FN_TREBLE: bus.treble     <= clamp_tone(d[3:0]);
          FN_MASTER: bus.master_vol <= clamp_master(d);
          FN_RIGHT:  bus.right_vol  <= clamp_side(d[4:0]);
          FN_LEFT:   bus.left_vol   <= clamp_side(d[4:0]);
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_lmc1992_receiver.sv
// Randomised + directed bench for lmc1992_receiver with a register-level
// model: every frame is turned into an expected register snapshot and
// applied at the cycle its pulse must appear; gains are recomputed from
// the dB formula one cycle after the registers.
module tb_lmc1992_receiver;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 2;   // en_n rise driven -> pulse visible

  logic clk32 = 1'b0;
  logic reset = 1'b1;
  lmc1992_receiver_if bus();

  lmc1992_receiver #(.SYNC_STAGES(SYNC), .DEV_ADDR(2'b10)) dut (
    .clk32(clk32), .reset(reset), .bus(bus)
  );

  always #15 clk32 = ~clk32;

  int cyc = 0;
  always @(posedge clk32) cyc <= cyc + 1;

  int checks = 0, passes = 0;

  typedef struct {
    int mix, bass, treble, master, left, right;
  } regs_t;
  typedef struct {
    int    at;
    bit    err;
    regs_t r;
  } ev_t;

  ev_t   q[$];
  regs_t cur, prev, proj;
  bit    ev_v, ev_e;

  function automatic regs_t defaults();
    regs_t r;
    r.mix = 1; r.bass = 6; r.treble = 6; r.master = 40; r.left = 20; r.right = 20;
    return r;
  endfunction

  function automatic int gain_of(int master, int side);
    int k;
    k = (40 - master) + (20 - side);
    if (k >= 40) return 0;
    return $rtoi(255.0 * (10.0 ** (-k / 10.0)) + 0.5 + 1e-9);
  endfunction

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk32) begin
    ev_v = 1'b0;
    ev_e = 1'b0;
    if (reset) begin
      cur = defaults();
      prev = cur;
      q.delete();
    end else begin
      if (q.size() > 0 && q[0].at == cyc) begin
        ev_e = q[0].err;
        ev_v = !q[0].err;
        if (!q[0].err) cur = q[0].r;
        void'(q.pop_front());
      end
      chk("cmd_valid",  int'(bus.cmd_valid),  int'(ev_v));
      chk("frame_err",  int'(bus.frame_err),  int'(ev_e));
      chk("mix",        int'(bus.mix),        cur.mix);
      chk("bass",       int'(bus.bass),       cur.bass);
      chk("treble",     int'(bus.treble),     cur.treble);
      chk("master_vol", int'(bus.master_vol), cur.master);
      chk("left_vol",   int'(bus.left_vol),   cur.left);
      chk("right_vol",  int'(bus.right_vol),  cur.right);
      chk("gain_left",  int'(bus.gain_left),  gain_of(prev.master, prev.left));
      chk("gain_right", int'(bus.gain_right), gain_of(prev.master, prev.right));
      prev = cur;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk32);
    #1;
  endtask

  // Send nbits of 'bits' MSB first; 'same' closes the frame on the last clock edge.
  task automatic send(input logic [15:0] bits, input int nbits, input bit same);
    ev_t e;
    int  fn, d;
    bit  hit;
    bus.mw_en_n = 1'b0;
    tick(4);
    for (int i = nbits - 1; i >= 0; i--) begin
      bus.mw_data = bits[i];
      tick(3);
      bus.mw_clk = 1'b1;
      if (i == 0 && same) bus.mw_en_n = 1'b1;
      else begin
        tick(3);
        bus.mw_clk = 1'b0;
      end
    end
    if (!same) begin
      tick(3);
      bus.mw_en_n = 1'b1;
    end
    hit = 1'b0;
    e.at = cyc + LAT;
    e.err = 1'b0;
    if (nbits != 11) begin
      e.err = 1'b1;
      hit = 1'b1;
    end else if (bits[10:9] == 2'b10) begin
      fn = int'(bits[8:6]);
      d  = int'(bits[5:0]);
      hit = 1'b1;
      case (fn)
        0: proj.mix    = d % 4;
        1: proj.bass   = imin(d % 16, 12);
        2: proj.treble = imin(d % 16, 12);
        3: proj.master = imin(d, 40);
        4: proj.right  = imin(d % 32, 20);
        5: proj.left   = imin(d % 32, 20);
        default: hit = 1'b0;
      endcase
    end
    e.r = proj;
    if (hit) q.push_back(e);
    tick(3);
    bus.mw_clk = 1'b0;
    tick(LAT + 4);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.mw_en_n = 1'b1;
    bus.mw_clk = 1'b0;
    bus.mw_data = 1'b0;
    proj = defaults();
    tick(3);
    reset = 1'b0;
    tick(4);
  endtask

  initial begin
    logic [15:0] fr;
    int nb;
    bus.mw_en_n = 1'b1;
    bus.mw_clk = 1'b0;
    bus.mw_data = 1'b0;
    proj = defaults();
    tick(3);
    reset = 1'b0;
    tick(4);

    chk("rst_mix",    int'(bus.mix), 1);
    chk("rst_bass",   int'(bus.bass), 6);
    chk("rst_master", int'(bus.master_vol), 40);
    chk("rst_gain_l", int'(bus.gain_left), 255);
    chk("rst_gain_r", int'(bus.gain_right), 255);

    send(16'h4D4, 11, 1'b0);
    chk("m20_master", int'(bus.master_vol), 20);
    chk("m20_gain_l", int'(bus.gain_left), 3);
    chk("m20_gain_r", int'(bus.gain_right), 3);

    send(16'h4E8, 11, 1'b0);           // master back to 40
    send(16'h50A, 11, 1'b0);           // right = 10
    chk("r10_right",  int'(bus.right_vol), 10);
    chk("r10_gain_r", int'(bus.gain_right), 26);
    chk("r10_gain_l", int'(bus.gain_left), 255);
    send(16'h54A, 11, 1'b0);           // left = 10
    chk("l10_left",   int'(bus.left_vol), 10);
    chk("l10_gain_l", int'(bus.gain_left), 26);

    send(16'h135, 10, 1'b0);           // short frame
    send(16'hA95, 12, 1'b0);           // long frame
    chk("err_left",   int'(bus.left_vol), 10);
    send(16'h2D4, 11, 1'b0);           // wrong address
    chk("addr_master", int'(bus.master_vol), 40);
    send(16'h44F, 11, 1'b0);           // bass 15 clamps
    chk("bass_clamp", int'(bus.bass), 12);
    send(16'h48A, 11, 1'b1);           // last bit on the closing edge
    chk("same_treble", int'(bus.treble), 10);

    // Reset in the middle of a frame, then a clean frame.
    send(16'h4D4, 11, 1'b0);
    bus.mw_en_n = 1'b0;
    tick(4);
    for (int i = 0; i < 5; i++) begin
      bus.mw_data = 1'($urandom_range(1));
      tick(3);
      bus.mw_clk = 1'b1;
      tick(3);
      bus.mw_clk = 1'b0;
    end
    do_reset();
    chk("mid_rst_master", int'(bus.master_vol), 40);
    send(16'h4D4, 11, 1'b0);
    chk("post_rst_master", int'(bus.master_vol), 20);
    chk("post_rst_bass",   int'(bus.bass), 6);

    for (int n = 0; n < 40; n++) begin
      fr = 16'($urandom);
      fr[10:9] = ($urandom_range(7) == 0) ? 2'($urandom) : 2'b10;
      case ($urandom_range(5))
        0: nb = 10;
        1: nb = 12;
        default: nb = 11;
      endcase
      send(fr, nb, 1'($urandom_range(1)));
      // Clock activity between frames must be ignored.
      bus.mw_data = 1'($urandom_range(1));
      bus.mw_clk = 1'b1;
      tick(3);
      bus.mw_clk = 1'b0;
      tick(3);
    end

    tick(LAT + 4);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
